// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite pixel pipeline.
package sprite_pkg;

  localparam int unsigned COLOR_W = 12;

  typedef logic [COLOR_W-1:0] rgb_t;

  // Total input-to-output latency: address stage, ROM read, final pixel stage.
  function automatic int unsigned pipe_latency(input int unsigned rom_lat);
    return rom_lat + 2;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Resettable shift register used to keep timing and flags aligned with the pixel pipeline.
module sync_delay
  import sprite_pkg::*;
#(
  parameter int unsigned           WIDTH     = 1,
  parameter int unsigned           DEPTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_pixel_pipe.sv
// Composites one palettized sprite over a background colour on the XVGA raster.
// Define SPRITE_TRANSPARENCY_EN to make palette index 0 show the background.
module sprite_pixel_pipe
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W    = 64,
  parameter int unsigned SPRITE_H    = 64,
  parameter int unsigned ROM_LATENCY = 2,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              vclock_in,
  input  logic              rst_n_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  input  logic              pos_we_in,
  input  logic [10:0]       pos_x_in,
  input  logic [9:0]        pos_y_in,
  input  logic              pal_we_in,
  input  logic [IDX_W-1:0]  pal_idx_in,
  input  rgb_t              pal_data_in,
  input  rgb_t              bg_in,
  output logic [ADDR_W-1:0] rom_addr_out,
  input  logic [IDX_W-1:0]  rom_data_in,
  output rgb_t              pixel_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out
);

  localparam int unsigned L     = pipe_latency(ROM_LATENCY);
  localparam int unsigned PAL_N = 2 ** IDX_W;

  // Position double-buffer
  logic [10:0] shadow_x_q, shadow_x_d, act_x_q, act_x_d;
  logic [9:0]  shadow_y_q, shadow_y_d, act_y_q, act_y_d;
  logic        pending_q, pending_d;
  logic        vsync_prev_q;
  logic        vsync_fall;

  assign vsync_fall = vsync_prev_q & ~vsync_in;

  always_comb begin
    shadow_x_d = shadow_x_q;
    shadow_y_d = shadow_y_q;
    act_x_d    = act_x_q;
    act_y_d    = act_y_q;
    pending_d  = pending_q;
    if (vsync_fall && pending_q) begin
      act_x_d   = shadow_x_q;
      act_y_d   = shadow_y_q;
      pending_d = 1'b0;
    end
    // A write on the commit cycle lands after the commit, so it waits a frame.
    if (pos_we_in) begin
      shadow_x_d = pos_x_in;
      shadow_y_d = pos_y_in;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge vclock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shadow_x_q   <= '0;
      shadow_y_q   <= '0;
      act_x_q      <= '0;
      act_y_q      <= '0;
      pending_q    <= 1'b0;
      vsync_prev_q <= 1'b1;
    end else begin
      shadow_x_q   <= shadow_x_d;
      shadow_y_q   <= shadow_y_d;
      act_x_q      <= act_x_d;
      act_y_q      <= act_y_d;
      pending_q    <= pending_d;
      vsync_prev_q <= vsync_in;
    end
  end

  // Stage 0: box test and ROM address; widened sums clip at the edge instead of wrapping
  logic [11:0]       x_end;
  logic [10:0]       y_end;
  logic [10:0]       dx;
  logic [9:0]        dy;
  logic              in_box;
  logic [ADDR_W-1:0] rom_addr_d;

  assign x_end  = {1'b0, act_x_q} + 12'(SPRITE_W);
  assign y_end  = {1'b0, act_y_q} + 11'(SPRITE_H);
  assign dx     = hcount_in - act_x_q;
  assign dy     = vcount_in - act_y_q;
  assign in_box = (hcount_in >= act_x_q) && ({1'b0, hcount_in} < x_end) &&
                  (vcount_in >= act_y_q) && ({1'b0, vcount_in} < y_end);

  always_comb begin
    rom_addr_d = '0;
    if (in_box) begin
      rom_addr_d = ADDR_W'(32'(dy) * 32'(SPRITE_W) + 32'(dx));
    end
  end

  logic [ADDR_W-1:0] rom_addr_q;
  logic              in_box_q, blank_s0_q;

  always_ff @(posedge vclock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rom_addr_q <= '0;
      in_box_q   <= 1'b0;
      blank_s0_q <= 1'b1;
    end else begin
      rom_addr_q <= rom_addr_d;
      in_box_q   <= in_box;
      blank_s0_q <= blank_in;
    end
  end

  assign rom_addr_out = rom_addr_q;

  // Blank rides alongside in_box so the final stage sees it one cycle before blank_out.
  logic in_box_dly, blank_dly;

  sync_delay #(
    .WIDTH    (2),
    .DEPTH    (ROM_LATENCY),
    .RESET_VAL(2'b01)
  ) u_box_delay (
    .clk_i (vclock_in),
    .rst_ni(rst_n_in),
    .d_i   ({in_box_q, blank_s0_q}),
    .q_o   ({in_box_dly, blank_dly})
  );

  sync_delay #(
    .WIDTH    (3),
    .DEPTH    (L),
    .RESET_VAL(3'b111)
  ) u_sync_delay (
    .clk_i (vclock_in),
    .rst_ni(rst_n_in),
    .d_i   ({hsync_in, vsync_in, blank_in}),
    .q_o   ({hsync_out, vsync_out, blank_out})
  );

  // Palette register file
  rgb_t pal_q [PAL_N];

  always_ff @(posedge vclock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < PAL_N; i++) begin
        pal_q[i] <= '0;
      end
    end else if (pal_we_in) begin
      pal_q[pal_idx_in] <= pal_data_in;
    end
  end

  logic idx_transparent;
`ifdef SPRITE_TRANSPARENCY_EN
  assign idx_transparent = (rom_data_in == '0);
`else
  assign idx_transparent = 1'b0;
`endif

  // Final stage
  rgb_t pixel_d, pixel_q;

  always_comb begin
    pixel_d = bg_in;
    if (blank_dly) begin
      pixel_d = '0;
    end else if (in_box_dly && !idx_transparent) begin
      pixel_d = pal_q[rom_data_in];
    end
  end

  always_ff @(posedge vclock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_q <= '0;
    end else begin
      pixel_q <= pixel_d;
    end
  end

  assign pixel_out = pixel_q;

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Randomized bench for sprite_pixel_pipe against a per-pixel reference model.
module tb_sprite_pixel_pipe;

  localparam int SW = 64;
  localparam int SH = 64;
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b1;
  logic        pos_we = 1'b0;
  logic [10:0] pos_x = '0;
  logic [9:0]  pos_y = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = '0;
  logic [11:0] pal_data = '0;
  logic [11:0] bg = '0;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data;
  logic [11:0] pixel;
  logic        hs_o, vs_o, bl_o;

  always #5 clk = ~clk;

  sprite_pixel_pipe u_dut (
    .vclock_in   (clk),
    .rst_n_in    (rst_n),
    .hcount_in   (hcount),
    .vcount_in   (vcount),
    .hsync_in    (hsync),
    .vsync_in    (vsync),
    .blank_in    (blank),
    .pos_we_in   (pos_we),
    .pos_x_in    (pos_x),
    .pos_y_in    (pos_y),
    .pal_we_in   (pal_we),
    .pal_idx_in  (pal_idx),
    .pal_data_in (pal_data),
    .bg_in       (bg),
    .rom_addr_out(rom_addr),
    .rom_data_in (rom_data),
    .pixel_out   (pixel),
    .hsync_out   (hs_o),
    .vsync_out   (vs_o),
    .blank_out   (bl_o)
  );

  // Sprite ROM with two cycles of read latency
  logic [3:0] rom_mem [4096];
  logic [3:0] rom_p1, rom_p2;
  always @(posedge clk) begin
    rom_p1 <= rom_mem[rom_addr];
    rom_p2 <= rom_p1;
  end
  assign rom_data = rom_p2;

  // Reference model
  typedef struct {
    int x; int y;
    logic hs; logic vs; logic bl;
    bit ib; int idx;
  } exp_t;

  exp_t        q[$];
  int          m_ax, m_ay, m_sx, m_sy;
  bit          m_pend;
  logic        m_prev_vs;
  logic [11:0] m_pal [16];
  int          n_vec = 0, n_fail = 0;

  function automatic logic hs_of(int x);
    return !(x >= 1048 && x < 1184);
  endfunction
  function automatic logic vs_of(int y);
    return !(y >= 771 && y < 777);
  endfunction
  function automatic logic bl_of(int x, int y);
    return (x >= 1024) || (y >= 768);
  endfunction

  task automatic model_reset();
    exp_t idle;
    m_ax = 0; m_ay = 0; m_sx = 0; m_sy = 0; m_pend = 0; m_prev_vs = 1'b1;
    for (int i = 0; i < 16; i++) m_pal[i] = '0;
    idle = '{x: -1, y: -1, hs: 1'b1, vs: 1'b1, bl: 1'b1, ib: 1'b0, idx: 0};
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(idle);
  endtask

  // Drive one raster position for one clock and score the outputs that emerge.
  task automatic step(input int x, input int y);
    exp_t e, o;
    int addr;
    bit ib;
    logic [11:0] want;
    hcount = 11'(x); vcount = 10'(y);
    hsync = hs_of(x); vsync = vs_of(y); blank = bl_of(x, y);
    ib = (x >= m_ax) && (x < m_ax + SW) && (y >= m_ay) && (y < m_ay + SH);
    addr = ib ? ((y - m_ay) * SW + (x - m_ax)) % 4096 : 0;
    e = '{x: x, y: y, hs: hsync, vs: vsync, bl: blank, ib: ib,
          idx: ib ? int'(rom_mem[addr]) : 0};
    if (rst_n) q.push_back(e);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      n_vec++;
      if ({pixel, hs_o, vs_o, bl_o, rom_addr} !== {12'h000, 3'b111, 12'h000}) begin
        n_fail++;
        $display("FAIL reset_idle: got pix=%h hs=%b vs=%b bl=%b addr=%h want 000/1/1/1/000",
                 pixel, hs_o, vs_o, bl_o, rom_addr);
      end
    end else begin
      n_vec++;
      if (rom_addr !== 12'(addr)) begin
        n_fail++;
        $display("FAIL rom_addr @(%0d,%0d): got %0d want %0d", x, y, rom_addr, addr);
      end
      if (q.size() == 4) begin
        o = q.pop_front();
        if (o.bl) want = 12'h000;
        else if (o.ib && !(TRANSP && o.idx == 0)) want = m_pal[o.idx];
        else want = bg;
        n_vec++;
        if ({pixel, hs_o, vs_o, bl_o} !== {want, o.hs, o.vs, o.bl}) begin
          n_fail++;
          $display("FAIL pixel_out @(%0d,%0d): got pix=%h hs=%b vs=%b bl=%b want %h/%b/%b/%b",
                   o.x, o.y, pixel, hs_o, vs_o, bl_o, want, o.hs, o.vs, o.bl);
        end
      end
      if (pal_we) m_pal[pal_idx] = pal_data;
      if (m_prev_vs && !vsync && m_pend) begin
        m_ax = m_sx; m_ay = m_sy; m_pend = 0;
      end
      if (pos_we) begin
        m_sx = int'(pos_x); m_sy = int'(pos_y); m_pend = 1;
      end
      m_prev_vs = vsync;
    end
    pal_we = 1'b0;
    pos_we = 1'b0;
  endtask

  task automatic line(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) step(x, y);
  endtask

  task automatic write_pal(input int idx, input logic [11:0] data);
    pal_we = 1'b1; pal_idx = 4'(idx); pal_data = data;
    step(1200, 780);
  endtask

  task automatic write_pos(input int px, input int py, input int x, input int y);
    pos_we = 1'b1; pos_x = 11'(px); pos_y = 10'(py);
    step(x, y);
  endtask

  // Vertical sync fall at (1100,771); optionally a position write on that exact cycle.
  task automatic frame_flip(input bit we, input int px, input int py);
    line(770, 1100, 1103);
    if (we) begin
      pos_we = 1'b1; pos_x = 11'(px); pos_y = 10'(py);
    end
    step(1100, 771);
    line(771, 1101, 1103);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(1200, 780);
    rst_n = 1'b1;
    n_vec++;
    if ({pixel, hs_o, vs_o, bl_o, rom_addr} !== {12'h000, 3'b111, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_values: got pix=%h hs=%b vs=%b bl=%b addr=%h", pixel, hs_o, vs_o,
               bl_o, rom_addr);
    end
    line(780, 1200, 1210);
  endtask

  task automatic test_background();
    bg = 12'($urandom);
    line(100, 0, 1343);
    line(500, 0, 1343);
    line(767, 1000, 1343);
    line(768, 0, 50);
  endtask

  task automatic test_sprite_box();
    for (int i = 0; i < 16; i++) write_pal(i, 12'($urandom));
    write_pal(5, 12'hF00);
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'd5;
    bg = 12'h0A5;
    write_pos(100, 50, 1200, 780);
    frame_flip(1'b0, 0, 0);
    line(49, 90, 170);
    for (int x = 99; x <= 102; x++) step(x, 50);
    n_vec++;
    if (pixel !== 12'h0A5) begin
      n_fail++;
      $display("FAIL left_of_box (99,50): got %h want 0a5", pixel);
    end
    step(103, 50);
    n_vec++;
    if (pixel !== 12'hF00) begin
      n_fail++;
      $display("FAIL box_corner (100,50): got %h want f00", pixel);
    end
    line(50, 104, 170);
    line(51, 90, 100);
    step(101, 51);
    n_vec++;
    if (rom_addr !== 12'd65) begin
      n_fail++;
      $display("FAIL rom_addr_101_51: got %0d want 65", rom_addr);
    end
    line(51, 102, 170);
    line(113, 90, 170);
    line(114, 90, 170);
  endtask

  task automatic test_edge_clip();
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom);
    for (int i = 0; i < 16; i++) write_pal(i, 12'($urandom));
    write_pos(1000, 740, 1200, 780);
    frame_flip(1'b0, 0, 0);
    line(739, 990, 1030);
    line(740, 990, 1343);
    line(767, 990, 1343);
    line(768, 990, 1030);
    line(741, 1300, 1343);
    line(742, 0, 45);
    line(0, 990, 1023);
    line(1, 0, 45);
  endtask

  task automatic test_midframe_pos();
    logic [3:0] idx0;
    logic [11:0] want;
    line(299, 290, 300);
    write_pos(300, 290, 400, 299);
    line(300, 280, 319);
    for (int x = 320; x <= 323; x++) step(x, 300);
    n_vec++;
    if (pixel !== bg) begin
      n_fail++;
      $display("FAIL old_frame_keeps_pos (320,300): got %h want %h", pixel, bg);
    end
    line(300, 324, 420);
    frame_flip(1'b1, 500, 100);
    line(300, 280, 319);
    idx0 = rom_mem[(300 - 290) * SW + 20];
    want = (TRANSP && idx0 == 4'd0) ? bg : m_pal[idx0];
    for (int x = 320; x <= 323; x++) step(x, 300);
    n_vec++;
    if (pixel !== want) begin
      n_fail++;
      $display("FAIL new_pos_after_flip (320,300): got %h want %h", pixel, want);
    end
    line(300, 324, 420);
    line(100, 490, 570);
    frame_flip(1'b0, 0, 0);
    line(100, 490, 570);
  endtask

  task automatic test_transparency();
    logic [11:0] p0;
    p0 = 12'($urandom_range(1, 4095));
    write_pal(0, p0);
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'd0;
    bg = 12'h3C3;
    line(120, 490, 509);
    for (int x = 510; x <= 513; x++) step(x, 120);
    n_vec++;
    if (pixel !== (TRANSP ? 12'h3C3 : p0)) begin
      n_fail++;
      $display("FAIL index0 (510,120): got %h want %h", pixel, TRANSP ? 12'h3C3 : p0);
    end
    line(120, 514, 570);
  endtask

  task automatic test_back_to_back();
    step(1200, 780);
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        pal_we = 1'b1; pal_idx = 4'($urandom); pal_data = 12'($urandom);
      end
      if ($urandom_range(0, 31) == 0) begin
        pos_we = 1'b1; pos_x = 11'($urandom_range(0, 1100)); pos_y = 10'($urandom_range(0, 800));
      end
      if ($urandom_range(0, 63) == 0) bg = 12'($urandom);
      step($urandom_range(0, 1343), $urandom_range(0, 805));
    end
  endtask

  task automatic test_reset_midframe();
    line(200, 480, 499);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({pixel, hs_o, vs_o, bl_o, rom_addr} !== {12'h000, 3'b111, 12'h000}) begin
      n_fail++;
      $display("FAIL async_reset_idle: got pix=%h hs=%b vs=%b bl=%b addr=%h", pixel, hs_o, vs_o,
               bl_o, rom_addr);
    end
    model_reset();
    line(200, 500, 502);
    rst_n = 1'b1;
    line(200, 503, 505);
    n_vec++;
    if (bl_o !== 1'b1) begin
      n_fail++;
      $display("FAIL still_idle_after_release: got blank=%b want 1", bl_o);
    end
    step(506, 200);
    n_vec++;
    if ({bl_o, hs_o, vs_o, pixel} !== {1'b0, 1'b1, 1'b1, bg}) begin
      n_fail++;
      $display("FAIL resume_after_release (503,200): got bl=%b hs=%b vs=%b pix=%h want 0/1/1/%h",
               bl_o, hs_o, vs_o, pixel, bg);
    end
    line(200, 507, 540);
    line(10, 0, 100);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = '0;
    #2;
    test_reset();
    test_background();
    test_sprite_box();
    test_edge_clip();
    test_midframe_pos();
    test_transparency();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
